// File: rtl/arm_datapath_pkg.sv
// Shared encodings for the multicycle ARM-subset datapath: mux selects,
// ALU operations, immediate forms and ALUFlags bit positions.
package arm_datapath_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_MOV = 3'b101;

  localparam logic [1:0] IMM_8    = 2'b00;
  localparam logic [1:0] IMM_12   = 2'b01;
  localparam logic [1:0] IMM_BR   = 2'b10;
  localparam logic [1:0] IMM_ZERO = 2'b11;

  localparam logic [1:0] SRCA_A      = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;
  localparam logic [1:0] SRCA_ZERO   = 2'b11;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] SRCB_ZERO = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_ALU2   = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] PC_REG = 4'd15;

endpackage

// File: rtl/arm_regfile.sv
// R0-R14 register file: two combinational read ports, one synchronous write
// port; address 15 reads the externally supplied r15 value and ignores writes.
module arm_regfile
  import arm_datapath_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we3,
  input  logic [3:0]  ra1,
  input  logic [3:0]  ra2,
  input  logic [3:0]  wa3,
  input  logic [31:0] wd3,
  input  logic [31:0] r15,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] rf_q [15];
  logic [31:0] rf_d [15];

  always_comb begin
    rf_d = rf_q;
    if (we3 && (wa3 != PC_REG)) rf_d[wa3] = wd3;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // Reads see pre-edge contents, so a same-cycle write is not forwarded.
  assign rd1 = (ra1 == PC_REG) ? r15 : rf_q[ra1];
  assign rd2 = (ra2 == PC_REG) ? r15 : rf_q[ra2];

endmodule

// File: rtl/arm_datapath.sv
// Multicycle ARM-subset datapath driven by per-cycle control strobes.
// Define ROT_IMM_EN to make ImmSrc=00 produce the rotated data-processing immediate.
module arm_datapath
  import arm_datapath_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] Adr,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData,
  output logic [31:0] Instr,
  output logic [3:0]  ALUFlags,
  input  logic        PCWrite,
  input  logic        RegWrite,
  input  logic        IRWrite,
  input  logic        AdrSrc,
  input  logic [1:0]  RegSrc,
  input  logic [1:0]  ALUSrcA,
  input  logic [1:0]  ALUSrcB,
  input  logic [1:0]  ResultSrc,
  input  logic [1:0]  ImmSrc,
  input  logic [2:0]  ALUControl
);

  logic [31:0] pc_q, pc_d, instr_q, instr_d, data_q, data_d;
  logic [31:0] a_q, a_d, wd_q, wd_d, aluout_q, aluout_d;
  logic [31:0] rd1, rd2, ext_imm, src_a, src_b, alu_result, result;
  logic [3:0]  ra1, ra2;

`ifdef ROT_IMM_EN
  function automatic logic [31:0] rot_imm(input logic [11:0] f);
    return 32'({2{24'd0, f[7:0]}} >> {f[11:8], 1'b0});
  endfunction
`endif

  // Returns {flags, result}; C/V are only meaningful for ADD/SUB.
  function automatic logic [35:0] alu_eval(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] ctl);
    logic        sub, arith;
    logic [31:0] bb, y;
    logic [32:0] sum;
    logic [3:0]  f;
    sub   = (ctl == ALU_SUB);
    arith = (ctl == ALU_ADD) || sub || (ctl > ALU_MOV);
    bb    = sub ? ~b : b;
    sum   = {1'b0, a} + {1'b0, bb} + {32'd0, sub};
    case (ctl)
      ALU_AND: y = a & b;
      ALU_ORR: y = a | b;
      ALU_EOR: y = a ^ b;
      ALU_MOV: y = b;
      default: y = sum[31:0];
    endcase
    f[FLAG_N] = y[31];
    f[FLAG_Z] = (y == 32'd0);
    f[FLAG_C] = arith & sum[32];
    f[FLAG_V] = arith & (a[31] == bb[31]) & (sum[31] != a[31]);
    return {f, y};
  endfunction

  assign ra1 = RegSrc[0] ? PC_REG : instr_q[19:16];
  assign ra2 = RegSrc[1] ? instr_q[15:12] : instr_q[3:0];

  arm_regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .we3   (RegWrite),
    .ra1   (ra1),
    .ra2   (ra2),
    .wa3   (instr_q[15:12]),
    .wd3   (result),
    .r15   (result),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  always_comb begin
    ext_imm = '0;
    case (ImmSrc)
`ifdef ROT_IMM_EN
      IMM_8:    ext_imm = rot_imm(instr_q[11:0]);
`else
      IMM_8:    ext_imm = {24'd0, instr_q[7:0]};
`endif
      IMM_12:   ext_imm = {20'd0, instr_q[11:0]};
      IMM_BR:   ext_imm = {{6{instr_q[23]}}, instr_q[23:0], 2'b00};
      IMM_ZERO: ext_imm = '0;
    endcase

    src_a = '0;
    case (ALUSrcA)
      SRCA_A:      src_a = a_q;
      SRCA_PC:     src_a = pc_q;
      SRCA_ALUOUT: src_a = aluout_q;
      SRCA_ZERO:   src_a = '0;
    endcase

    src_b = '0;
    case (ALUSrcB)
      SRCB_WD:   src_b = wd_q;
      SRCB_IMM:  src_b = ext_imm;
      SRCB_FOUR: src_b = 32'd4;
      SRCB_ZERO: src_b = '0;
    endcase

    {ALUFlags, alu_result} = alu_eval(src_a, src_b, ALUControl);

    result = alu_result;
    case (ResultSrc)
      RES_ALUOUT:         result = aluout_q;
      RES_DATA:           result = data_q;
      RES_ALU, RES_ALU2:  result = alu_result;
    endcase
  end

  assign Adr       = AdrSrc ? result : pc_q;
  assign Instr     = instr_q;
  assign WriteData = wd_q;

  always_comb begin
    pc_d     = PCWrite ? result : pc_q;
    instr_d  = IRWrite ? ReadData : instr_q;
    data_d   = ReadData;
    a_d      = rd1;
    wd_d     = rd2;
    aluout_d = alu_result;
  end

  // Architectural and non-architectural latches share one clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= '0;
      instr_q  <= '0;
      data_q   <= '0;
      a_q      <= '0;
      wd_q     <= '0;
      aluout_q <= '0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      data_q   <= data_d;
      a_q      <= a_d;
      wd_q     <= wd_d;
      aluout_q <= aluout_d;
    end
  end

endmodule

// File: tb/tb_arm_datapath.sv
// Bench for arm_datapath: directed scenarios plus random strobes, all checked
// against an arithmetic reference model of the datapath state.
module tb_arm_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Adr, WriteData, ReadData, Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0]  ALUControl;

  arm_datapath dut (
    .clk        (clk),
    .reset      (reset),
    .Adr        (Adr),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .RegSrc     (RegSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] m_pc, m_instr, m_data, m_a, m_wd, m_aluout;
  logic [31:0] m_rf [15];

  task automatic m_reset();
    m_pc = 0; m_instr = 0; m_data = 0; m_a = 0; m_wd = 0; m_aluout = 0;
    for (int i = 0; i < 15; i++) m_rf[i] = 0;
  endtask

  function automatic logic [31:0] m_ext(input logic [31:0] ins, input logic [1:0] s);
    int          s24;
    int          r;
    logic [31:0] v;
    case (s)
      2'd0: begin
        v = {24'd0, ins[7:0]};
`ifdef ROT_IMM_EN
        r = 2 * int'(ins[11:8]);
        if (r != 0) v = (v >> r) | (v << (32 - r));
`else
        r = 0;
`endif
        return v;
      end
      2'd1: return {20'd0, ins[11:0]};
      2'd2: begin
        s24 = $signed(ins[23:0]);
        return 32'(s24 * 4);
      end
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                       output logic [31:0] y, output logic [3:0] f);
    longint ss;
    logic   cf, vf;
    cf = 0; vf = 0;
    case (c)
      3'd1: begin
        y  = a - b;
        cf = (a >= b);
        ss = longint'($signed(a)) - longint'($signed(b));
        vf = (ss != longint'($signed(y)));
      end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: y = b;
      default: begin
        y  = a + b;
        cf = ({32'd0, a} + {32'd0, b}) > 64'h0000_0000_FFFF_FFFF;
        ss = longint'($signed(a)) + longint'($signed(b));
        vf = (ss != longint'($signed(y)));
      end
    endcase
    f = {y[31], y == 32'd0, cf, vf};
  endtask

  function automatic logic [31:0] m_rd(input logic [3:0] ra, input logic [31:0] res);
    return (ra == 4'd15) ? res : m_rf[ra];
  endfunction

  // Called just after a negedge with inputs already driven; checks, then advances one edge.
  task automatic tick();
    logic [31:0] ext, sa, sb, y, res, r1, r2;
    logic [3:0]  f;
    #1;
    ext = m_ext(m_instr, ImmSrc);
    case (ALUSrcA)
      2'd0: sa = m_a;  2'd1: sa = m_pc;  2'd2: sa = m_aluout;  default: sa = 0;
    endcase
    case (ALUSrcB)
      2'd0: sb = m_wd; 2'd1: sb = ext;   2'd2: sb = 4;         default: sb = 0;
    endcase
    m_alu(sa, sb, ALUControl, y, f);
    res = (ResultSrc == 2'd0) ? m_aluout : (ResultSrc == 2'd1) ? m_data : y;
    r1  = m_rd(RegSrc[0] ? 4'd15 : m_instr[19:16], res);
    r2  = m_rd(RegSrc[1] ? m_instr[15:12] : m_instr[3:0], res);
    chk("adr",   Adr, AdrSrc ? res : m_pc);
    chk("flags", {28'd0, ALUFlags}, {28'd0, f});
    chk("instr", Instr, m_instr);
    chk("wdata", WriteData, m_wd);
    chk("instr_known", 32'($isunknown(Instr)), 32'd0);
    @(posedge clk);
    if (RegWrite && m_instr[15:12] != 4'd15) m_rf[m_instr[15:12]] = res;
    if (PCWrite) m_pc = res;
    if (IRWrite) m_instr = ReadData;
    m_data = ReadData; m_a = r1; m_wd = r2; m_aluout = y;
    @(negedge clk);
  endtask

  task automatic idle();
    PCWrite = 0; RegWrite = 0; IRWrite = 0; AdrSrc = 0; RegSrc = 0;
    ALUSrcA = 2'b11; ALUSrcB = 2'b11; ResultSrc = 2'b10; ImmSrc = 0;
    ALUControl = 0; ReadData = 0;
  endtask

  task automatic fetch_instr(input logic [31:0] v);
    idle(); IRWrite = 1; ReadData = v; tick();
  endtask

  // Load path: Data <= value, then ResultSrc=01 writes it to Rd.
  task automatic load_reg(input logic [3:0] rd, input logic [31:0] val);
    fetch_instr({16'hE590, rd, 12'h000});
    idle(); ReadData = val; tick();
    idle(); ResultSrc = 2'b01; RegWrite = 1; tick();
  endtask

  task automatic read_pair();
    idle(); RegSrc = 2'b00; tick();
  endtask

  task automatic rand_tick();
    PCWrite    = 1'($urandom);
    RegWrite   = 1'($urandom);
    IRWrite    = 1'($urandom);
    AdrSrc     = 1'($urandom);
    RegSrc     = 2'($urandom);
    ALUSrcA    = 2'($urandom);
    ALUSrcB    = 2'($urandom);
    ResultSrc  = 2'($urandom);
    ImmSrc     = 2'($urandom);
    ALUControl = 3'($urandom);
    ReadData   = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF + 32'($urandom_range(0, 2)) : $urandom;
    tick();
  endtask

  initial begin
    idle();
    reset = 1;
    m_reset();
    #3;
    chk("rst_adr", Adr, 32'd0);
    chk("rst_instr", Instr, 32'd0);
    chk("rst_wdata", WriteData, 32'd0);
    @(negedge clk);
    IRWrite = 1; ReadData = 32'hE3A0_0005;
    #1 chk("rst_adr_hold", Adr, 32'd0);
    reset = 0;
    tick();
    chk("fetch_instr", Instr, 32'hE3A0_0005);

    // PC increments by 4 per fetch
    idle(); PCWrite = 1; ALUSrcA = 2'b01; ALUSrcB = 2'b10; ALUControl = 0; ResultSrc = 2'b10;
    tick();
    chk("pc4", Adr, 32'd4);
    tick();
    chk("pc8", Adr, 32'd8);

    // R1 = 7; ADD R1, R1, #5
    load_reg(4'd1, 32'd7);
    fetch_instr(32'hE281_1005);
    read_pair();
    idle(); ALUSrcA = 2'b00; ALUSrcB = 2'b01; ImmSrc = 2'b00; ALUControl = 3'b000; tick();
    idle(); ResultSrc = 2'b00; RegWrite = 1; AdrSrc = 1;
    #1 chk("add_aluout", Adr, 32'd12);
    tick();
    read_pair();
    idle(); ALUSrcA = 2'b00; ALUSrcB = 2'b11; AdrSrc = 1;
    #1 chk("add_rd", Adr, 32'd12);
    tick();

    // SUB 9-9 and ADD overflow flags
    load_reg(4'd2, 32'd9);
    fetch_instr(32'hE042_2002);
    read_pair();
    idle(); ALUSrcA = 2'b00; ALUSrcB = 2'b00; ALUControl = 3'b001;
    #1 chk("sub_flags", {28'd0, ALUFlags}, 32'h6);
    tick();
    load_reg(4'd3, 32'h7FFF_FFFF);
    load_reg(4'd4, 32'd1);
    fetch_instr(32'hE083_5004);
    read_pair();
    idle(); ALUSrcA = 2'b00; ALUSrcB = 2'b00; ALUControl = 3'b000;
    #1 chk("ovf_flags", {28'd0, ALUFlags}, 32'h9);
    tick();

    // Load: address from Result, data written back next cycle
    fetch_instr(32'hE590_6080);
    idle(); ALUSrcB = 2'b01; AdrSrc = 1; ReadData = 32'hFE;
    #1 chk("load_adr", Adr, 32'h80);
    tick();
    idle(); ResultSrc = 2'b01; RegWrite = 1; AdrSrc = 1;
    #1 chk("load_data", Adr, 32'hFE);
    tick();
    fetch_instr(32'hE596_6000);
    read_pair();
    idle(); ALUSrcA = 2'b00; AdrSrc = 1;
    #1 chk("load_rd", Adr, 32'hFE);
    tick();

    // Branch -8 from PC+8 lands on PC (PC is 8)
    fetch_instr(32'hEAFF_FFFE);
    idle(); ALUSrcA = 2'b01; ALUSrcB = 2'b10; tick();
    idle(); ALUSrcA = 2'b10; ALUSrcB = 2'b10; tick();
    idle(); ALUSrcA = 2'b10; ALUSrcB = 2'b01; ImmSrc = 2'b10; AdrSrc = 1;
    #1 chk("branch", Adr, 32'd8);
    tick();

    // imm8 = 0xFF with rotate field 4
    fetch_instr(32'hE3A0_04FF);
    idle(); ALUSrcB = 2'b01; ALUControl = 3'b101; AdrSrc = 1;
`ifdef ROT_IMM_EN
    #1 chk("imm8", Adr, 32'hFF00_0000);
`else
    #1 chk("imm8", Adr, 32'h0000_00FF);
`endif
    tick();

    repeat (400) rand_tick();

    // Asynchronous reset in mid-cycle with strobes active
    PCWrite = 1; RegWrite = 1; IRWrite = 1; AdrSrc = 0;
    #2 reset = 1;
    #1;
    chk("mid_rst_adr", Adr, 32'd0);
    chk("mid_rst_instr", Instr, 32'd0);
    chk("mid_rst_wdata", WriteData, 32'd0);
    @(negedge clk);
    reset = 0;
    m_reset();
    repeat (200) rand_tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
